// File: rtl/imem_line_server_pkg.sv
// Shared constants and types for the instruction-line refill responder.
// Line geometry and FSM state codes; also used by the fetch stage.
package imem_line_server_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_TAG_W     = 28;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic logic [31:0] line_base_addr(input logic [LINE_TAG_W-1:0] tag);
        return {tag, 4'b0000};
    endfunction

endpackage

// File: rtl/imem_lat_pipe.sv
// Read-in-flight tracker: shifts one valid bit per issued memory read.
// Latency MEM_LAT cycles, ret_valid lines up with the memory read data.
// No backpressure; one issue per cycle, sync active-low clear.
module imem_lat_pipe #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic issue,
    output logic ret_valid,
    output logic in_flight
);

    logic [MEM_LAT-1:0] vld_sr;

    generate
        if (MEM_LAT == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!clr_n) vld_sr <= '0;
                else        vld_sr <= issue;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (!clr_n) vld_sr <= '0;
                else        vld_sr <= {vld_sr[MEM_LAT-2:0], issue};
            end
        end
    endgenerate

    assign ret_valid = vld_sr[MEM_LAT-1];
    assign in_flight = |vld_sr;

endmodule

// File: rtl/imem_line_server.sv
// Serves 128-bit instruction-line refills by reading four words from backing memory.
// Latency: line_valid 5+MEM_LAT cycles after accept; four reads back to back.
// Backpressure: req_ready only when idle; the line pulse itself cannot be stalled.
module imem_line_server
    import imem_line_server_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              line_valid,
    output logic [LINE_W-1:0] line_data,
    output logic [31:0]       line_addr
);

    state_t                      state, state_nxt;
    logic [LINE_TAG_W-1:0]       req_tag;
    logic [1:0]                  iss_cnt;
    logic                        iss_done;
    logic [1:0]                  cap_cnt;
    logic [LINE_W-WORD_W-1:0]    asm_buf;
    logic                        accept;
    logic                        issue;
    logic                        capture;
    logic                        last_word;
    logic                        ret_valid;
    logic                        in_flight;
    logic                        unused_addr_bits;

    // Byte offset within the line is irrelevant to a whole-line refill.
    assign unused_addr_bits = ^req_addr[3:0];

    // Gated by rst so every output reads 0 while reset is held.
    assign req_ready = rst && (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign issue     = (state == S_FILL) && !iss_done && !flush;
    assign capture   = (state == S_FILL) && ret_valid && !flush;
    assign last_word = capture && (cap_cnt == 2'd3);

    assign mem_rd_en  = issue;
    assign mem_addr   = issue ? {req_tag[ADDR_W-3:0], iss_cnt} : '0;
    assign line_valid = (state == S_RESP);

    imem_lat_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_pipe (
        .clk       (clk),
        .clr_n     (rst),
        .issue     (issue),
        .ret_valid (ret_valid),
        .in_flight (in_flight)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_FILL;
            S_FILL: begin
                if (flush)          state_nxt = S_DRAIN;
                else if (last_word) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            S_DRAIN: if (!in_flight) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            req_tag   <= '0;
            iss_cnt   <= '0;
            iss_done  <= 1'b0;
            cap_cnt   <= '0;
            asm_buf   <= '0;
            line_data <= '0;
            line_addr <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_tag  <= req_addr[31:4];
                iss_cnt  <= '0;
                iss_done <= 1'b0;
                cap_cnt  <= '0;
            end
            if (issue) begin
                iss_cnt <= iss_cnt + 2'd1;
                if (iss_cnt == 2'd3) iss_done <= 1'b1;
            end
            if (capture) begin
                cap_cnt <= cap_cnt + 2'd1;
                unique case (cap_cnt)
                    2'd0:    asm_buf[31:0]  <= mem_rd_data;
                    2'd1:    asm_buf[63:32] <= mem_rd_data;
                    2'd2:    asm_buf[95:64] <= mem_rd_data;
                    default: ;
                endcase
            end
            // Published only on the final word so the outputs hold between pulses.
            if (last_word) begin
                line_data <= {mem_rd_data, asm_buf};
                line_addr <= line_base_addr(req_tag);
            end
        end
    end

endmodule
